// File: rtl/spi_master_wb_fifo.sv
// spi_master_wb_fifo: Wishbone SPI master with TX/RX FIFOs, CPOL/CPHA modes and a wide clock divider
module spi_master_wb_fifo #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SS_WIDTH = 1,
  parameter int DIV_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [2:0]          adr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  output logic                ack_o,
  output logic                inta_o,
  output logic                sck_o,
  output logic                mosi_o,
  input  logic                miso_i,
  output logic [SS_WIDTH-1:0] ss_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(2*DATA_W);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic spie, spe, cpol, cpha, spif, wcol, cpha_q;
  logic [DIV_W-1:0] sper, div_q, div_cnt;
  logic [SS_WIDTH-1:0] ssr;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] tsh, rsh;
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0] tx_cnt, rx_cnt;
  logic acc, wr, rd, tx_push, tx_pop, rx_push, rx_pop, tick, abort, load, done;
  logic tx_full, tx_empty, rx_full, rx_empty, unused;
  logic [31:0] rdata;
  assign unused = &{1'b0, dat_i};
  assign acc = cyc_i & stb_i & ~ack_o;
  assign wr = acc & we_i;
  assign rd = acc & ~we_i;
  assign tx_full = tx_cnt == (AW+1)'(FIFO_DEPTH);
  assign tx_empty = tx_cnt == '0;
  assign rx_full = rx_cnt == (AW+1)'(FIFO_DEPTH);
  assign rx_empty = rx_cnt == '0;
  assign tx_push = wr && adr_i == 3'd2 && !tx_full;
  assign rx_pop = rd && adr_i == 3'd2 && !rx_empty;
  assign inta_o = spie & spif;
  assign ss_o = ~ssr;
  assign rdata = adr_i == 3'd0 ? {24'd0, spie, spe, 1'b0, 1'b1, cpol, cpha, 2'b0} :
                 adr_i == 3'd1 ? {24'd0, spif, wcol, 2'b0, tx_full, tx_empty, rx_full, rx_empty} :
                 adr_i == 3'd2 ? (rx_empty ? 32'd0 : 32'(rx_mem[rx_rp])) :
                 adr_i == 3'd3 ? 32'(sper) :
                 adr_i == 3'd4 ? 32'(ssr) : 32'd0;
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (spe && !tx_empty ? LOAD : IDLE) :
               abort ? IDLE :
               state == LOAD ? SHIFT :
               state == SHIFT ? (tick && cnt == CW'(2*DATA_W-1) ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    abort = !spe && (state == LOAD || state == SHIFT);
    load = state == LOAD && spe;
    done = state == DONE;
    tick = state == SHIFT && spe && div_cnt == div_q;
    tx_pop = load;
    rx_push = done && !rx_full;
  end
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp] <= dat_i[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp] <= rsh;
  end
  always_ff @(posedge clk_i)
    if (rst_i || abort) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_cnt <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop) tx_rp <= tx_rp + AW'(1);
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop) rx_rp <= rx_rp + AW'(1);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      {spie, spe, cpol, cpha, spif, wcol} <= '0;
      sper <= '0;
      ssr <= '0;
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= acc;
      dat_o <= rd ? rdata : 32'd0;
      if (wr && adr_i == 3'd0) {spie, spe, cpol, cpha} <= {dat_i[7:6], dat_i[3:2]};
      if (wr && adr_i == 3'd3) sper <= dat_i[DIV_W-1:0];
      if (wr && adr_i == 3'd4) ssr <= dat_i[SS_WIDTH-1:0];
      spif <= done | (spif & ~(wr && adr_i == 3'd1 && dat_i[7]));
      wcol <= (wr && adr_i == 3'd2 && tx_full) | (wcol & ~(wr && adr_i == 3'd1 && dat_i[6]));
    end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      sck_o <= 1'b0;
      mosi_o <= 1'b0;
      cnt <= '0;
      div_cnt <= '0;
      div_q <= '0;
      cpha_q <= 1'b0;
      tsh <= '0;
      rsh <= '0;
    end else begin
      if (state == IDLE || abort) sck_o <= cpol;
      if (load) begin
        tsh <= tx_mem[tx_rp];
        cnt <= '0;
        div_cnt <= '0;
        div_q <= sper;
        cpha_q <= cpha;
        sck_o <= cpol;
        if (!cpha) mosi_o <= tx_mem[tx_rp][DATA_W-1];
      end
      if (tick) begin
        sck_o <= ~sck_o;
        cnt <= cnt + CW'(1);
        div_cnt <= '0;
        if (cnt[0] == cpha_q) rsh <= {rsh[DATA_W-2:0], miso_i};
        else begin
          tsh <= {tsh[DATA_W-2:0], 1'b0};
          mosi_o <= cpha_q ? tsh[DATA_W-1] : tsh[DATA_W-2];
        end
      end else if (state == SHIFT) div_cnt <= div_cnt + DIV_W'(1);
    end
endmodule
